phy_mgmt_ctrl: RTL and testbench

//  Sequences the four RGMII PHYs on the NF1 CML board: holds phy_rstn low after reset, waits for the PHYs to settle, then

---
 rtl/phy_mgmt_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_phy_mgmt_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mgmt_ctrl.sv
// PHY bring-up sequencer and Clause 22 MDIO master for the four RGMII PHYs.
// Releases phy_rstn, writes one init register per PHY, then serves one-deep host reads/writes.
module phy_mgmt_ctrl #(
    parameter int          MDC_DIV         = 50,
    parameter int          RST_CYCLES      = 2000,
    parameter int          POST_RST_CYCLES = 1000000,
    parameter logic [4:0]  PHY_ADDR_BASE   = 5'd0,
    parameter logic [4:0]  INIT_REG        = 5'd0,
    parameter logic [15:0] INIT_DATA       = 16'h1140
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  phy_rstn,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    input  logic        host_req,
    input  logic        host_rnw,
    input  logic [4:0]  host_phy,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        init_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);
    // Host handshake: host_req is a level held with stable fields until host_ack (one-cycle
    // pulse) is seen; the requester drops it on the next edge so IDLE never re-issues.
    localparam int WAIT_MAX = (RST_CYCLES > POST_RST_CYCLES) ? RST_CYCLES : POST_RST_CYCLES;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int DIV_W    = $clog2(MDC_DIV);
    localparam logic [WAIT_W-1:0] RST_LAST  = WAIT_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] POST_LAST = WAIT_W'(POST_RST_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MDC_DIV - 1);

    typedef enum logic [2:0] {
        RST_HOLD   = 3'd0,
        RST_WAIT   = 3'd1,
        INIT_FRAME = 3'd2,
        IDLE       = 3'd3,
        HOST_FRAME = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic [1:0]        init_idx;
    logic [63:0]       frame_sr;
    logic              frame_rnw;
    logic [15:0]       rd_sr;

    logic              in_frame;
    logic              frame_end;
    logic              launch;
    logic              launch_rnw;
    logic [4:0]        launch_phy;
    logic [4:0]        launch_reg;
    logic [15:0]       launch_dat;
    logic [63:0]       frame_bits;

    // Whole frame, bit 0 in the MSB; read frames carry 1s where the bus is released.
    function automatic logic [63:0] build_frame(input logic rnw, input logic [4:0] phy,
                                                input logic [4:0] regad, input logic [15:0] data);
        return {32'hFFFF_FFFF, 2'b01, (rnw ? 2'b10 : 2'b01), phy, regad,
                (rnw ? 18'h3_FFFF : {2'b10, data})};
    endfunction

    assign state_dbg  = state;
    assign in_frame   = (state == INIT_FRAME) || (state == HOST_FRAME);
    assign frame_end  = in_frame && mdc && (div_cnt == DIV_LAST) && (bit_cnt == 6'd63);
    assign frame_bits = build_frame(launch_rnw, launch_phy, launch_reg, launch_dat);

    always_comb begin
        launch     = 1'b0;
        launch_rnw = 1'b0;
        launch_phy = PHY_ADDR_BASE + {3'b000, init_idx};
        launch_reg = INIT_REG;
        launch_dat = INIT_DATA;
        case (state)
            RST_WAIT:   launch = (wait_cnt == POST_LAST);
            INIT_FRAME: begin
                launch     = frame_end && (init_idx != 2'd3);
                launch_phy = PHY_ADDR_BASE + {3'b000, init_idx} + 5'd1;
            end
            IDLE: begin
                launch     = host_req;
                launch_rnw = host_rnw;
                launch_phy = host_phy;
                launch_reg = host_reg;
                launch_dat = host_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_HOLD;
            wait_cnt   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            init_idx   <= '0;
            frame_sr   <= '1;
            frame_rnw  <= 1'b0;
            rd_sr      <= '0;
            phy_rstn   <= 4'h0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_t     <= 1'b1;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            host_ack <= 1'b0;

            // Bit timing: output changes with the MDC fall, mdio_i captured with the MDC rise.
            if (in_frame) begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    mdc     <= ~mdc;
                    if (!mdc) begin
                        if (frame_rnw && (bit_cnt >= 6'd48)) begin
                            rd_sr <= {rd_sr[14:0], mdio_i};
                        end
                    end else if (bit_cnt != 6'd63) begin
                        bit_cnt  <= bit_cnt + 6'd1;
                        frame_sr <= {frame_sr[62:0], 1'b1};
                        mdio_o   <= frame_sr[62];
                        mdio_t   <= frame_rnw && (bit_cnt >= 6'd45);
                    end else begin
                        mdio_o <= 1'b1;
                        mdio_t <= 1'b1;
                    end
                end
            end

            case (state)
                RST_HOLD: begin
                    if (wait_cnt == RST_LAST) begin
                        wait_cnt <= '0;
                        phy_rstn <= 4'hF;
                        state    <= RST_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (launch) state <= INIT_FRAME;
                    else        wait_cnt <= wait_cnt + 1'b1;
                end
                INIT_FRAME: begin
                    if (frame_end) begin
                        if (init_idx == 2'd3) begin
                            state     <= IDLE;
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (launch) begin
                        state <= HOST_FRAME;
                        busy  <= 1'b1;
                    end
                end
                HOST_FRAME: begin
                    if (frame_end) begin
                        state    <= DONE;
                        host_ack <= 1'b1;
                        if (frame_rnw) host_rdata <= rd_sr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= RST_HOLD;
            endcase

            // A new frame starts with MDC low and bit 0 already on the wire.
            if (launch) begin
                frame_sr  <= frame_bits;
                frame_rnw <= launch_rnw;
                mdio_o    <= frame_bits[63];
                mdio_t    <= 1'b0;
                mdc       <= 1'b0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Bench for phy_mgmt_ctrl: MDIO slave model decodes frames on the bus and a queue-based
// reference model of expected frames, read data and acks checks them.
`timescale 1ns/1ps
module tb_phy_mgmt_ctrl;
    localparam int MDC_DIV         = 2;
    localparam int RST_CYCLES      = 8;
    localparam int POST_RST_CYCLES = 16;
    localparam int W               = 27;
    localparam int LIMIT           = 4000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  phy_rstn;
    logic        mdc, mdio_o, mdio_t, mdio_i;
    logic        host_req, host_rnw;
    logic [4:0]  host_phy, host_reg;
    logic [15:0] host_wdata, host_rdata;
    logic        host_ack, init_done, busy;
    logic [2:0]  state_dbg;
    logic        slave_drv = 1'b1;

    assign mdio_i = mdio_t ? slave_drv : mdio_o;

    always #5 clk = ~clk;

    phy_mgmt_ctrl #(
        .MDC_DIV(MDC_DIV), .RST_CYCLES(RST_CYCLES), .POST_RST_CYCLES(POST_RST_CYCLES),
        .PHY_ADDR_BASE(5'd0), .INIT_REG(5'd0), .INIT_DATA(16'h1140)
    ) dut (
        .clk(clk), .reset(reset), .phy_rstn(phy_rstn), .mdc(mdc), .mdio_o(mdio_o),
        .mdio_t(mdio_t), .mdio_i(mdio_i), .host_req(host_req), .host_rnw(host_rnw),
        .host_phy(host_phy), .host_reg(host_reg), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .init_done(init_done),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [W-1:0] exp_q[$];          // {rnw, phy, reg, data}
    logic [15:0]  slave_data = 16'h0;
    logic [15:0]  last_rdata = 16'h0;
    int           ack_cnt  = 0;
    int           exp_acks = 0;
    int           frames   = 0;
    int           cyc      = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (host_ack === 1'b1) ack_cnt++;

    // ---------------- MDIO slave model ----------------
    int          rise_cnt  = 0;
    int          start_cyc = 0;
    logic [63:0] fb = '0;
    logic [63:0] tv = '0;
    logic        slave_rd = 1'b0;

    task automatic decode_frame();
        logic [W-1:0] exp_e;
        logic [W-1:0] got;
        check("frame_len", 64'(cyc - start_cyc), 64'(63 * 2 * MDC_DIV));
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() == 0) return;
        exp_e = exp_q.pop_front();
        check("frame_hdr", fb[63:28], {32'hFFFF_FFFF, 2'b01, (exp_e[W-1] ? 2'b10 : 2'b01)});
        got = {(fb[29:28] == 2'b10), fb[27:23], fb[22:18], fb[15:0]};
        check("frame_fields", got, exp_e);
        if (!exp_e[W-1]) check("frame_ta", fb[17:16], 2'b10);
        check("frame_mdio_t", tv, exp_e[W-1] ? 64'h3_FFFF : 64'h0);
    endtask

    always @(posedge mdc or posedge reset) begin
        if (reset) begin
            rise_cnt = 0;
            fb       = '0;
            tv       = '0;
            slave_rd = 1'b0;
            frames   = 0;
        end else begin
            if (rise_cnt == 0) start_cyc = cyc;
            fb = {fb[62:0], mdio_i};
            tv = {tv[62:0], mdio_t};
            rise_cnt++;
            if (rise_cnt == 36) slave_rd = (fb[1:0] == 2'b10);
            if (rise_cnt == 64) begin
                decode_frame();
                rise_cnt = 0;
                slave_rd = 1'b0;
                frames++;
            end
        end
    end

    always @(negedge mdc or posedge reset) begin
        if (reset)                                          slave_drv = 1'b1;
        else if (slave_rd && rise_cnt >= 48 && rise_cnt <= 63) slave_drv = slave_data[63 - rise_cnt];
        else                                                slave_drv = 1'b1;
    end

    // init_done must rise on the cycle right after the last MDC-high cycle of frame 4
    logic prev_init = 1'b0;
    logic prev_mdc  = 1'b0;
    always @(negedge clk) begin
        if (init_done === 1'b1 && prev_init === 1'b0)
            check("init_done_timing", {prev_mdc, mdc, 4'(frames)}, {1'b1, 1'b0, 4'd4});
        prev_init = init_done;
        prev_mdc  = mdc;
    end

    // ---------------- driver tasks ----------------
    task automatic push_init();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 5'(i), 5'd0, 16'h1140});
    endtask

    // called at a negedge; returns at a negedge with reset released
    task automatic apply_reset();
        reset    = 1'b1;
        host_req = 1'b0;
        #1;
        check("rst_phy_rstn", phy_rstn, 4'h0);
        check("rst_mdc", mdc, 1'b0);
        check("rst_mdio", {mdio_o, mdio_t}, 2'b11);
        check("rst_ack", host_ack, 1'b0);
        check("rst_rdata", host_rdata, 16'h0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b1);
        exp_q.delete();
        last_rdata = 16'h0;
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b0;
    endtask

    task automatic bring_up(input bit inject);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!busy) busy_ok = 1'b0;
        end while (phy_rstn != 4'hF && n < 100);
        check("rstn_low_cycles", n, RST_CYCLES);
        check("rstn_release", phy_rstn, 4'hF);
        if (inject) begin
            host_rnw   = 1'b0;
            host_phy   = 5'd1;
            host_reg   = 5'd4;
            host_wdata = 16'h01E1;
            exp_q.push_back({1'b0, 5'd1, 5'd4, 16'h01E1});
            exp_acks++;
            host_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy) busy_ok = 1'b0;
        end while (!mdc && n < 100);
        check("first_mdc_delay", n, POST_RST_CYCLES + MDC_DIV);
        n = 0;
        while (!init_done && n < LIMIT) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("init_done", init_done, 1'b1);
        check("busy_during_bringup", busy_ok, 1'b1);
        check("init_frames", frames, 4);
    endtask

    task automatic wait_ack(input bit hold);
        int n;
        n = 0;
        while (host_ack !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", host_ack, 1'b1);
        check("ack_after_init", init_done, 1'b1);
        check("host_rdata", host_rdata, last_rdata);
        if (!hold) host_req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", host_ack, 1'b0);
        check("idle_after_ack", busy, 1'b0);
    endtask

    task automatic host_xact(input logic rnw, input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] wdata, input logic [15:0] sdata, input bit hold);
        bit b2b;
        b2b        = host_req;
        host_rnw   = rnw;
        host_phy   = phy;
        host_reg   = regad;
        host_wdata = wdata;
        slave_data = sdata;
        exp_q.push_back({rnw, phy, regad, (rnw ? sdata : wdata)});
        if (rnw) last_rdata = sdata;
        exp_acks++;
        host_req = 1'b1;
        if (b2b) begin
            @(negedge clk);
            check("b2b_start", {busy, mdc}, 2'b10);
            @(negedge clk);
            check("b2b_mdc_low", mdc, 1'b0);
            @(negedge clk);
            check("b2b_mdc_rise", mdc, 1'b1);
        end
        wait_ack(hold);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int acks_before;
        reset      = 1'b1;
        host_req   = 1'b0;
        host_rnw   = 1'b0;
        host_phy   = '0;
        host_reg   = '0;
        host_wdata = '0;
        @(negedge clk);
        apply_reset();

        // request raised while the PHYs are still settling; must follow the four init writes
        bring_up(1'b1);
        wait_ack(1'b0);

        // fixed read
        host_xact(1'b1, 5'd2, 5'd2, 16'h0, 16'h0141, 1'b0);
        // write then read with host_req held across both
        host_xact(1'b0, 5'd1, 5'd4, 16'h01E1, 16'h0, 1'b1);
        host_xact(1'b1, 5'd31, 5'd31, 16'h0, 16'hBEEF, 1'b0);

        // random transactions
        for (int i = 0; i < 8; i++) begin
            host_xact(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      (i == 7) ? 1'b0 : 1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("ack_count", ack_cnt, exp_acks);

        // reset in the middle of a host read frame
        host_rnw   = 1'b1;
        host_phy   = 5'd3;
        host_reg   = 5'd9;
        slave_data = 16'hA5A5;
        host_req   = 1'b1;
        n = 0;
        while (rise_cnt < 40 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit40", rise_cnt >= 40, 1'b1);
        acks_before = ack_cnt;
        apply_reset();
        bring_up(1'b0);
        repeat (20) @(negedge clk);
        check("no_ack_after_reset", ack_cnt, acks_before);
        check("idle_after_replay", {busy, mdc, mdio_t}, 3'b001);

        host_xact(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
        repeat (10) @(negedge clk);
        check("queue_empty_end", exp_q.size(), 0);
        check("ack_count_end", ack_cnt, acks_before + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
